// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types, constants and helpers for the CNN layer scheduler
package cnn_pkg;

    // Width of the inference cycle counter
    localparam int SCHED_COUNT_WIDTH = 32;

    // Scheduler sequencing states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_NEXT   = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } sched_state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [SCHED_COUNT_WIDTH-1:0] sat_inc(
        input logic [SCHED_COUNT_WIDTH-1:0] value
    );
        return (&value) ? value : value + SCHED_COUNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/sched_watchdog.sv
// rtl/sched_watchdog.sv - per-layer run-to-done watchdog for the layer scheduler
module sched_watchdog #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    // Number of cycles elapsed since the run pulse; the launch cycle itself
    // counts as one, so the first wait cycle already reads 1.
    logic [CW-1:0] count;

    // Load on launch, count while waiting, stick at the limit
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= CW'(1);
        end else if (enable && (count != CW'(TIMEOUT_CYCLES))) begin
            count <= count + CW'(1);
        end
    end

    // Fires on the last wait cycle that could still see a valid done, so the
    // scheduler lands in its error state exactly TIMEOUT_CYCLES after the run.
    assign expired = enable && (count >= CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/layer_scheduler.sv
// rtl/layer_scheduler.sv - sequences chained layer engines with ping-pong buffers and watchdog
module layer_scheduler
    import cnn_pkg::*;
#(
    parameter int NUM_LAYERS     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_start,
    input  logic                           i_abort,
    output logic [NUM_LAYERS-1:0]          layer_run,
    input  logic [NUM_LAYERS-1:0]          layer_done,
    output logic                           buf_sel,
    output logic [$clog2(NUM_LAYERS)-1:0]  cur_layer,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_error,
    output logic [$clog2(NUM_LAYERS)-1:0]  o_err_layer,
    output logic [SCHED_COUNT_WIDTH-1:0]   o_total_cycles
);

    localparam int             LW   = $clog2(NUM_LAYERS);
    localparam logic [LW-1:0]  LAST = LW'(NUM_LAYERS - 1);

    sched_state_e                  state;
    sched_state_e                  state_n;
    logic [LW-1:0]                 cur_n;
    logic                          buf_n;
    logic [LW-1:0]                 err_layer_n;
    logic [SCHED_COUNT_WIDTH-1:0]  total_n;
    logic [NUM_LAYERS-1:0]         run_n;
    logic [NUM_LAYERS-1:0]         cur_mask;
    logic                          valid_done;
    logic                          stray_done;
    logic                          wd_clear;
    logic                          wd_enable;
    logic                          wd_expired;

    assign wd_clear  = (state == S_LAUNCH);
    assign wd_enable = (state == S_WAIT);

    sched_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Split incoming done pulses into the active layer's and everyone else's
    always_comb begin
        cur_mask            = '0;
        cur_mask[cur_layer] = 1'b1;
    end

    assign valid_done = |(layer_done & cur_mask);
    assign stray_done = |(layer_done & ~cur_mask);

    // Next-state and next-register values; abort overrides everything
    always_comb begin
        state_n     = state;
        cur_n       = cur_layer;
        buf_n       = buf_sel;
        err_layer_n = o_err_layer;
        total_n     = o_total_cycles;

        // Every cycle from the first launch through the done cycle is billed,
        // including a cycle that ends up being aborted.
        if ((state == S_LAUNCH) || (state == S_WAIT) ||
            (state == S_NEXT)   || (state == S_DONE)) begin
            total_n = sat_inc(o_total_cycles);
        end

        if (i_abort && (state != S_IDLE)) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start && !i_abort) begin
                        state_n     = S_LAUNCH;
                        cur_n       = '0;
                        buf_n       = 1'b0;
                        total_n     = '0;
                        err_layer_n = '0;
                    end
                end
                S_LAUNCH: begin
                    if (stray_done) begin
                        state_n     = S_ERROR;
                        err_layer_n = cur_layer;
                    end else begin
                        state_n = S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Stray beats valid done, valid done beats the timeout
                    if (stray_done) begin
                        state_n     = S_ERROR;
                        err_layer_n = cur_layer;
                    end else if (valid_done) begin
                        state_n = (cur_layer == LAST) ? S_DONE : S_NEXT;
                    end else if (wd_expired) begin
                        state_n     = S_ERROR;
                        err_layer_n = cur_layer;
                    end
                end
                S_NEXT: begin
                    state_n = S_LAUNCH;
                    cur_n   = cur_layer + LW'(1);
                    buf_n   = ~buf_sel;
                end
                S_DONE: begin
                    state_n = S_IDLE;
                end
                S_ERROR: begin
                    state_n = S_ERROR;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    // Run pulse for the layer about to be launched
    always_comb begin
        run_n = '0;
        if (state_n == S_LAUNCH) begin
            run_n[cur_n] = 1'b1;
        end
    end

    // State and all outputs registered together from the next-state values
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            layer_run      <= '0;
            buf_sel        <= 1'b0;
            cur_layer      <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_error        <= 1'b0;
            o_err_layer    <= '0;
            o_total_cycles <= '0;
        end else begin
            state          <= state_n;
            layer_run      <= run_n;
            buf_sel        <= buf_n;
            cur_layer      <= cur_n;
            o_busy         <= (state_n != S_IDLE) && (state_n != S_ERROR);
            o_done         <= (state_n == S_DONE);
            o_error        <= (state_n == S_ERROR);
            o_err_layer    <= err_layer_n;
            o_total_cycles <= total_n;
        end
    end

endmodule

// File: tb/tb_layer_scheduler.sv
// tb/tb_layer_scheduler.sv - randomized self-checking bench for layer_scheduler
module tb_layer_scheduler;

    localparam int NL = 3;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_start;
    logic          i_abort;
    logic [NL-1:0] layer_run;
    logic [NL-1:0] layer_done;
    logic          buf_sel;
    logic [1:0]    cur_layer;
    logic          o_busy;
    logic          o_done;
    logic          o_error;
    logic [1:0]    o_err_layer;
    logic [31:0]   o_total_cycles;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    layer_scheduler #(
        .NUM_LAYERS     (NL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_start        (i_start),
        .i_abort        (i_abort),
        .layer_run      (layer_run),
        .layer_done     (layer_done),
        .buf_sel        (buf_sel),
        .cur_layer      (cur_layer),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_error        (o_error),
        .o_err_layer    (o_err_layer),
        .o_total_cycles (o_total_cycles)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; i_start = 1'b0; i_abort = 1'b0; layer_done = '0;
        step(); step();
        vectors++;
        if ({layer_run, buf_sel, cur_layer, o_busy, o_done, o_error, o_err_layer, o_total_cycles} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: run=%b buf=%b cur=%0d busy=%b done=%b err=%b el=%0d tot=%0d required all 0",
                     layer_run, buf_sel, cur_layer, o_busy, o_done, o_error, o_err_layer, o_total_cycles);
        end
        reset = 1'b0;
        step();
        vectors++;
        if (o_busy !== 1'b0 || layer_run !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b run=%b required 0/000", o_busy, layer_run);
        end
    endtask

    // One inference: delays d* are cycles from each run pulse to its done.
    // Optional stray done on layer sj while layer sk is active, offset soff
    // from its run pulse; optional i_start glitch at cycle gcyc while busy.
    task automatic run_inference(input int d0, input int d1, input int d2,
                                 input int sk, input int soff, input int sj,
                                 input int gcyc);
        int d[NL];
        int run_t[NL];
        bit launched[NL];
        int t, end_cyc, done_cyc, stray_cyc, exp_err_layer, exp_total;
        bit is_err;
        d[0] = d0; d[1] = d1; d[2] = d2;
        t = 1; end_cyc = -1; done_cyc = -1; stray_cyc = -1;
        exp_err_layer = 0; exp_total = 0; is_err = 0;
        for (int k = 0; k < NL; k++) launched[k] = 0;

        // Reference timeline: run at t, done d later, next run two cycles after done
        for (int k = 0; k < NL && end_cyc < 0; k++) begin
            int win_end;
            run_t[k] = t;
            launched[k] = 1;
            win_end = t + ((d[k] < TO) ? d[k] : TO - 1);
            if (k == sk) begin
                stray_cyc = t + soff;
                if (stray_cyc <= win_end) begin
                    is_err = 1; end_cyc = stray_cyc + 1;
                    exp_total = stray_cyc; exp_err_layer = k;
                end
            end
            if (end_cyc < 0) begin
                if (d[k] >= TO) begin
                    is_err = 1; end_cyc = t + TO;
                    exp_total = t + TO - 1; exp_err_layer = k;
                end else if (k == NL - 1) begin
                    end_cyc = t + d[k] + 1; done_cyc = end_cyc; exp_total = end_cyc;
                end else begin
                    t = t + d[k] + 2;
                end
            end
        end

        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int cyc = 1; cyc <= end_cyc + 1; cyc++) begin
            logic [NL-1:0] exp_run;
            logic [NL-1:0] drive;
            bit exp_busy;
            exp_run = '0;
            for (int k = 0; k < NL; k++) begin
                if (launched[k] && run_t[k] == cyc) begin
                    exp_run[k] = 1'b1;
                    vectors++;
                    if (buf_sel !== ((k % 2) == 1) || cur_layer !== 2'(k)) begin
                        errors++;
                        $display("FAIL launch_bank c%0d: buf_sel=%b cur_layer=%0d required %0d/%0d",
                                 cyc, buf_sel, cur_layer, k % 2, k);
                    end
                end
            end
            vectors++;
            if (layer_run !== exp_run) begin
                errors++;
                $display("FAIL layer_run c%0d: got %b required %b", cyc, layer_run, exp_run);
            end
            vectors++;
            if (o_done !== (cyc == done_cyc)) begin
                errors++;
                $display("FAIL o_done c%0d: got %b required %b", cyc, o_done, cyc == done_cyc);
            end
            vectors++;
            if (o_error !== (is_err && cyc >= end_cyc)) begin
                errors++;
                $display("FAIL o_error c%0d: got %b required %b", cyc, o_error, is_err && cyc >= end_cyc);
            end
            exp_busy = is_err ? (cyc < end_cyc) : (cyc <= end_cyc);
            vectors++;
            if (o_busy !== exp_busy) begin
                errors++;
                $display("FAIL o_busy c%0d: got %b required %b", cyc, o_busy, exp_busy);
            end
            drive = '0;
            for (int k = 0; k < NL; k++)
                if (launched[k] && cyc == run_t[k] + d[k]) drive[k] = 1'b1;
            if (cyc == stray_cyc) drive[sj] = 1'b1;
            layer_done = drive;
            i_start = (cyc == gcyc) && (cyc <= end_cyc);
            step();
        end
        layer_done = '0;
        i_start = 1'b0;

        vectors++;
        if (o_total_cycles !== 32'(exp_total)) begin
            errors++;
            $display("FAIL total_cycles: got %0d required %0d", o_total_cycles, exp_total);
        end
        vectors++;
        if (o_err_layer !== 2'(exp_err_layer)) begin
            errors++;
            $display("FAIL err_layer: got %0d required %0d", o_err_layer, exp_err_layer);
        end
        if (is_err) begin
            i_abort = 1'b1;
            step();
            i_abort = 1'b0;
            vectors++;
            if (o_error !== 1'b0 || o_busy !== 1'b0 || o_total_cycles !== 32'(exp_total)) begin
                errors++;
                $display("FAIL abort_clears_error: err=%b busy=%b tot=%0d required 0/0/%0d",
                         o_error, o_busy, o_total_cycles, exp_total);
            end
        end
        step();
    endtask

    task automatic test_normal();
        run_inference(5, 5, 5, -1, 0, 0, -1);
    endtask

    task automatic test_timeout();
        run_inference(5, 16, 5, -1, 0, 0, -1);
    endtask

    task automatic test_stray();
        run_inference(5, 5, 5, 0, 2, 2, -1);
    endtask

    task automatic test_race();
        run_inference(5, 15, 5, -1, 0, 0, -1);
    endtask

    task automatic test_ignored_start();
        run_inference(4, 6, 3, -1, 0, 0, 9);
        run_inference(4, 20, 3, -1, 0, 0, 27);
    endtask

    task automatic test_abort();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int cyc = 1; cyc < 10; cyc++) begin
            if (cyc == 8) begin
                vectors++;
                if (layer_run !== 3'b010) begin
                    errors++;
                    $display("FAIL abort_setup_run1: got %b required 010", layer_run);
                end
            end
            layer_done = (cyc == 6) ? 3'b001 : 3'b000;
            step();
        end
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (o_busy !== 1'b0 || o_done !== 1'b0 || layer_run !== '0) begin
                errors++;
                $display("FAIL abort_idle +%0d: busy=%b done=%b run=%b required 0/0/000",
                         i, o_busy, o_done, layer_run);
            end
            step();
        end
        run_inference(3, 3, 3, -1, 0, 0, -1);
    endtask

    task automatic test_reset_mid();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if ({layer_run, buf_sel, cur_layer, o_busy, o_done, o_error, o_err_layer, o_total_cycles} !== '0) begin
            errors++;
            $display("FAIL reset_mid: run=%b buf=%b cur=%0d busy=%b done=%b err=%b el=%0d tot=%0d required all 0",
                     layer_run, buf_sel, cur_layer, o_busy, o_done, o_error, o_err_layer, o_total_cycles);
        end
        step();
        vectors++;
        if (layer_run !== '0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stays_idle: run=%b busy=%b required 000/0", layer_run, o_busy);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            int d[NL];
            int sk, soff, sj, g;
            for (int k = 0; k < NL; k++) begin
                case ($urandom_range(0, 7))
                    0:       d[k] = $urandom_range(16, 20);
                    1:       d[k] = 15;
                    default: d[k] = $urandom_range(1, 14);
                endcase
            end
            sk = -1; soff = 0; sj = 0;
            if ($urandom_range(0, 3) == 0) begin
                sk   = $urandom_range(0, NL - 1);
                soff = $urandom_range(0, (d[sk] < TO) ? d[sk] : TO - 1);
                sj   = (sk + $urandom_range(1, NL - 1)) % NL;
            end
            g = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 20)) : -1;
            run_inference(d[0], d[1], d[2], sk, soff, sj, g);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_timeout();
        test_stray();
        test_race();
        test_ignored_start();
        test_abort();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/layer_scheduler.md
LAYER_SCHEDULER -- requirements
Module: layer_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_LAYERS, default 4, giving the number of chained layer engines sequenced.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 65535, giving the maximum cycles allowed between a layer's run pulse and its done pulse.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port i_start, input, 1 bit: start one inference.
REQ-006 The block SHALL have port i_abort, input, 1 bit: abandon the current inference, or clear an error.
REQ-007 The block SHALL have port layer_run, output, NUM_LAYERS bits: one-hot run pulse, one per layer engine.
REQ-008 The block SHALL have port layer_done, input, NUM_LAYERS bits: per-layer done pulses.
REQ-009 The block SHALL have port buf_sel, output, 1 bit: ping-pong activation BRAM bank select (0 = bank A is input, bank B is output).
REQ-010 The block SHALL have port cur_layer, output, $clog2(NUM_LAYERS) bits: index of the active layer.
REQ-011 The block SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE and not ERROR.
REQ-012 The block SHALL have port o_done, output, 1 bit: one-cycle pulse when inference completes.
REQ-013 The block SHALL have port o_error, output, 1 bit: level, high while in ERROR.
REQ-014 The block SHALL have port o_err_layer, output, $clog2(NUM_LAYERS) bits: layer index at which the error occurred.
REQ-015 The block SHALL have port o_total_cycles, output, 32 bits: inference cycle count, held after completion.

Function
REQ-016 The FSM SHALL have states S_IDLE, S_LAUNCH, S_WAIT, S_NEXT, S_DONE and S_ERROR.
REQ-017 In S_IDLE, i_start SHALL move the FSM to S_LAUNCH, clear cur_layer, buf_sel and o_total_cycles to 0, and clear o_err_layer.
REQ-018 In S_LAUNCH, layer_run[cur_layer] SHALL be 1 for exactly one cycle, all other layer_run bits SHALL be 0, and the next state SHALL be S_WAIT.
REQ-019 Latency: i_start sampled at cycle T SHALL give layer_run[0]=1 at cycle T+1.
REQ-020 In S_WAIT, layer_done[cur_layer]=1 at cycle D SHALL give S_NEXT at D+1 if cur_layer<NUM_LAYERS-1, else S_DONE at D+1.
REQ-021 S_NEXT SHALL increment cur_layer, toggle buf_sel and go to S_LAUNCH, so layer_run[k+1]=1 at cycle D+2.
REQ-022 S_DONE SHALL assert o_done for one cycle, then go to S_IDLE; buf_sel and cur_layer SHALL hold their values.
REQ-023 The watchdog counter SHALL clear in S_LAUNCH and increment in S_WAIT; when it reaches TIMEOUT_CYCLES without done, the FSM SHALL go to S_ERROR.
REQ-024 A layer_done bit for any non-active layer, asserted in S_WAIT or S_LAUNCH, SHALL send the FSM to S_ERROR.
REQ-025 Entering S_ERROR SHALL latch o_err_layer = cur_layer.
REQ-026 Simultaneous events: a valid layer_done[cur_layer] in the same cycle as the timeout SHALL win (no error).
REQ-027 Simultaneous events: a stray done on another layer SHALL take precedence over a valid done.
REQ-028 i_abort in any state other than S_IDLE SHALL force S_IDLE on the next cycle with no further run pulse and no o_done.
REQ-029 i_abort in S_ERROR SHALL clear o_error.
REQ-030 i_abort SHALL have priority over all other transitions.
REQ-031 i_start SHALL be ignored outside S_IDLE; S_ERROR SHALL be left only via i_abort or reset.
REQ-032 o_total_cycles SHALL increment every cycle from S_LAUNCH of layer 0 through S_DONE inclusive, saturating at 32'hFFFF_FFFF.
REQ-033 o_total_cycles SHALL hold its value in S_IDLE and S_ERROR.
REQ-034 layer_done SHALL be ignored in S_IDLE, S_DONE and S_NEXT.

Reset
REQ-035 Reset SHALL be synchronous and active-high, taking effect on the clk edge at which reset=1.
REQ-036 On reset, the FSM SHALL go to S_IDLE, and layer_run, buf_sel, cur_layer, o_busy, o_done, o_error, o_err_layer, o_total_cycles and the watchdog SHALL all be 0.
REQ-037 Reset asserted mid-inference SHALL abandon it with no run pulse on the following cycle.

Structure
REQ-038 The sched_state_e enum and the SCHED_COUNT_WIDTH=32 constant SHALL live in the shared package cnn_pkg.
REQ-039 The watchdog SHALL be a sub-module, sched_watchdog (inputs clear and enable, output expired; parameter TIMEOUT_CYCLES).
REQ-040 All outputs SHALL be decoded from registered state or registers, with no combinational path from input to output.

Verification
REQ-041 Normal run: NUM_LAYERS=3, TIMEOUT=16; i_start at cycle 0, each layer done 5 cycles after its run. Required: run pulses at cycles 1, 8 and 15; buf_sel sequence 0, 1, 0; o_done at cycle 21; o_total_cycles=21.
REQ-042 Timeout: layer 1 never asserts done. Required: S_ERROR 16 cycles after run[1]; o_error=1; o_err_layer=1; no run[2].
REQ-043 Stray done: layer_done[2] pulsed while layer 0 is active. Required: o_error=1 next cycle; o_err_layer=0.
REQ-044 Race: layer_done[cur] on the exact timeout cycle. Required: no error, and the next layer launches.
REQ-045 Abort and restart: i_abort during S_WAIT of layer 1. Required: S_IDLE next cycle, o_done never asserted; a following i_start gives run[0] one cycle later with buf_sel=0.
REQ-046 Reset and ignored start: reset mid-S_WAIT gives all outputs 0 the next cycle; i_start while busy causes no state change.
